sgd_sequencer: RTL
==================

// Module: sgd_sequencer
// PURPOSE
//  Control FSM for the SGD linear-regression datapath. It walks epochs x data points x features
//  and drives the following:
//   - the sample-memory read address
//   - the MAC, error and weight-update strobes
//  It starts once the serial loader reports the sample memory full. It raises SGD_DONE after the
//  last weight update of the last epoch.
// PARAMETERS
//  ADDR_W   16  sample-memory address width
//  STRIDE   12  words per data point (features first, target word at offset feat)
//  MAC_LAT  2   cycles from the last mac_en until the prediction is valid (1..7)
// PORTS
//  CLK          in   1       clock, rising edge
//  RST          in   1       reset; asynchronous, active-high
//  start        in   1       run request, sampled in IDLE
//  load_done    in   1       serial loader finished filling the sample memory
//  feat         in   4       features per point (0..11)
//  data_points  in   12      points per epoch
//  epoch        in   8       epochs to run
//  rd_addr      out  ADDR_W  sample-memory read address (synchronous read, 1-cycle latency)
//  rd_en        out  1       read enable, qualifies rd_addr
//  acc_clr      out  1       clear the prediction accumulator
//  mac_en       out  1       accumulate w[w_idx] * rdata
//  err_en       out  1       latch err = pred - rdata (rdata is the target)
//  upd_en       out  1       w[w_idx] -= lr * err * rdata
//  w_idx        out  4       weight index, aligned with mac_en/upd_en
//  busy         out  1       high from start acceptance until SGD_DONE
//  SGD_DONE     out  1       run complete (level)
//  epoch_cnt    out  8       current epoch index
//  pt_cnt       out  12      current point index
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; every output and counter is 0.
//  - Configuration:
//    - feat, data_points and epoch are latched on start acceptance.
//    - Later input changes are ignored until the next run.
//    - start while busy is ignored.
//  - Addressing:
//    - base = pt_cnt*STRIDE; rd_addr = base + f.
//    - rd_en=1 in PRED, ERR and UPD; rd_en=0 elsewhere.
//  - Strobe alignment:
//    - mac_en, err_en, upd_en and w_idx are the PRED/ERR/UPD address-phase decodes, registered
//      once, so they are 1 cycle behind rd_addr (aligned with rdata).
//    - acc_clr is not delayed: it pulses in the first PRED cycle of each point.
//  - FSM states and transitions:
//    - IDLE
//      - start && load_done  -> PRED (f=0).
//      - start && !load_done -> WAIT_LOAD.
//      - If the latched feat, data_points or epoch is 0 -> DONE directly. No strobes are issued.
//    - WAIT_LOAD: load_done -> PRED.
//    - PRED: f = 0..feat-1, one per cycle; then -> DRAIN.
//    - DRAIN: MAC_LAT cycles; the last delayed mac_en falls in the first DRAIN cycle. Then -> ERR.
//    - ERR: 1 cycle, rd_addr = base+feat; then -> UPD (f=0).
//    - UPD: f = 0..feat-1; then -> NEXT.
//    - NEXT: 1 cycle, in which the last delayed upd_en issues.
//      - pt_cnt++.
//      - If pt_cnt wraps at data_points: pt_cnt=0, epoch_cnt++.
//      - If epoch_cnt reaches epoch -> DONE, else -> PRED.
//    - DONE
//      - SGD_DONE=1, busy=0, counters hold.
//      - start -> clear counters, relatch configuration, proceed as from IDLE.
//  - Timing:
//    - Cycles per point = 2*feat + MAC_LAT + 2.
//    - SGD_DONE rises epoch*data_points*(2*feat+MAC_LAT+2) cycles after the first PRED cycle.
//  - Widths: rd_addr is computed at full ADDR_W with no wrap. The team guarantees
//    data_points*STRIDE <= 2^ADDR_W.
// TESTING
//  - Reset: RST=1 mid-UPD -> all outputs 0 in the same cycle. RST=0 then start=1 -> run restarts
//    at address 0.
//  - Single step: feat=2, data_points=1, epoch=1, MAC_LAT=2.
//    - rd_addr sequence: 0, 1, (drain x2), 2, 0, 1.
//    - mac_en at cycles 2-3, err_en at cycle 6, upd_en at cycles 7-8.
//    - SGD_DONE rises at cycle 9 (first PRED cycle = cycle 1).
//  - Wrap: feat=1, data_points=2, epoch=2.
//    - Base sequence: 0, 12, 0, 12.
//    - epoch_cnt steps 0 -> 1 after the second point; SGD_DONE after 4*6 = 24 cycles.
//  - Zero configuration: epoch=0 (and separately feat=0) -> SGD_DONE the next cycle; no
//    rd_en/mac_en/upd_en ever.
//  - Load gating: start with load_done=0 -> stays in WAIT_LOAD, busy=1, rd_en=0. load_done=1 ->
//    PRED begins the next cycle.
//  - Full run: feat=11, data_points=4, epoch=100, MAC_LAT=2 -> SGD_DONE after 10400 cycles;
//    exactly 4400 upd_en pulses.

Source files
------------

// File: rtl/sgd_sequencer.sv
// Control FSM for the SGD linear-regression datapath: walks epochs x points x features,
// driving sample-memory reads and the MAC / error / weight-update strobes.
module sgd_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int STRIDE  = 12,
    parameter int MAC_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              load_done,
    input  logic [3:0]        feat,
    input  logic [11:0]       data_points,
    input  logic [7:0]        epoch,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              acc_clr,
    output logic              mac_en,
    output logic              err_en,
    output logic              upd_en,
    output logic [3:0]        w_idx,
    output logic              busy,
    output logic              SGD_DONE,
    output logic [7:0]        epoch_cnt,
    output logic [11:0]       pt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LOAD, S_PRED, S_DRAIN, S_ERR, S_UPD, S_NEXT, S_DONE
    } state_t;

    state_t            state, next_state;
    logic [3:0]        feat_q;
    logic [11:0]       dp_q;
    logic [7:0]        ep_q;
    logic [3:0]        f;
    logic [2:0]        d;
    logic [ADDR_W-1:0] base;

    logic accept, cfg_zero, last_f, drain_last, last_pt, last_ep;

    assign accept     = start && (state == S_IDLE || state == S_DONE);
    assign cfg_zero   = (feat == 4'd0) || (data_points == 12'd0) || (epoch == 8'd0);
    assign last_f     = (f == feat_q - 4'd1);
    assign drain_last = (d == 3'(MAC_LAT - 1));
    assign last_pt    = (pt_cnt == dp_q - 12'd1);
    assign last_ep    = (epoch_cnt == ep_q - 8'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start)
                next_state = cfg_zero ? S_DONE : (load_done ? S_PRED : S_WAIT_LOAD);
            S_WAIT_LOAD: if (load_done) next_state = S_PRED;
            S_PRED:      if (last_f) next_state = S_DRAIN;
            S_DRAIN:     if (drain_last) next_state = S_ERR;
            S_ERR:       next_state = S_UPD;
            S_UPD:       if (last_f) next_state = S_NEXT;
            S_NEXT:      next_state = (last_pt && last_ep) ? S_DONE : S_PRED;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en    = (state == S_PRED) || (state == S_ERR) || (state == S_UPD);
        rd_addr  = '0;
        if (state == S_ERR)  rd_addr = base + ADDR_W'(feat_q);
        else if (rd_en)      rd_addr = base + ADDR_W'(f);
        acc_clr  = (state == S_PRED) && (f == 4'd0);
        busy     = (state != S_IDLE) && (state != S_DONE);
        SGD_DONE = (state == S_DONE);
    end

    // Base address is stepped by STRIDE alongside pt_cnt instead of multiplying.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            feat_q    <= '0;
            dp_q      <= '0;
            ep_q      <= '0;
            f         <= '0;
            d         <= '0;
            base      <= '0;
            pt_cnt    <= '0;
            epoch_cnt <= '0;
        end else if (accept) begin
            feat_q    <= feat;
            dp_q      <= data_points;
            ep_q      <= epoch;
            f         <= '0;
            d         <= '0;
            base      <= '0;
            pt_cnt    <= '0;
            epoch_cnt <= '0;
        end else begin
            case (state)
                S_PRED, S_UPD: f <= last_f ? 4'd0 : f + 4'd1;
                S_DRAIN:       d <= drain_last ? 3'd0 : d + 3'd1;
                S_NEXT: begin
                    if (last_pt) begin
                        pt_cnt    <= '0;
                        base      <= '0;
                        epoch_cnt <= epoch_cnt + 8'd1;
                    end else begin
                        pt_cnt <= pt_cnt + 12'd1;
                        base   <= base + ADDR_W'(STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes lag the address phase by one cycle so they line up with rdata.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mac_en <= 1'b0;
            err_en <= 1'b0;
            upd_en <= 1'b0;
            w_idx  <= '0;
        end else begin
            mac_en <= (state == S_PRED);
            err_en <= (state == S_ERR);
            upd_en <= (state == S_UPD);
            w_idx  <= (state == S_PRED || state == S_UPD) ? f : 4'd0;
        end
    end

endmodule
